// File: rtl/pulse_scheduler.sv
// Frame sequencer: plays a host-configured slot table, one channel sync per slot,
// holding that slot's pulse parameters on a shared bus for the slot's duration.
module pulse_scheduler #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SLOTS    = 8
) (
  input  logic                rst_n,
  input  logic                hi_clk,
  input  logic                i_enable,
  input  logic                i_frame_start,
  input  logic [4:0]          i_slot_count,
  input  logic                i_cfg_we,
  input  logic [3:0]          i_cfg_addr,
  input  logic [3:0]          i_cfg_ch,
  input  logic [7:0]          i_cfg_hit_len,
  input  logic [7:0]          i_cfg_gnd_len,
  input  logic [3:0]          i_cfg_pulse_count,
  input  logic [15:0]         i_cfg_hush_len,
  input  logic [15:0]         i_cfg_slot_len,
  output logic [CHANNELS-1:0] o_sync,
  output logic [7:0]          o_hit_len,
  output logic [7:0]          o_gnd_len,
  output logic [3:0]          o_pulse_count,
  output logic [15:0]         o_hush_len,
  output logic [3:0]          o_slot,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_overrun
);

  localparam int unsigned TAB_DEPTH = 16;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned CNT_W     = 5;

  typedef struct packed {
    logic [3:0]       ch;
    logic [7:0]       hit;
    logic [7:0]       gnd;
    logic [3:0]       pcount;
    logic [15:0]      hush;
    logic [LEN_W-1:0] slot_len;
  } slot_entry_t;

  typedef enum logic [1:0] {IDLE, SYNC, WAIT, DONE} state_t;

  state_t             state;
  slot_entry_t        tab [TAB_DEPTH];
  logic               prev_fs;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   eff_len;
  logic [CNT_W-1:0]   frame_cnt;

  logic               fs_edge;
  logic [CNT_W-1:0]   cnt_clamped;
  logic [3:0]         ld_idx;
  slot_entry_t        ld;
  logic [LEN_W-1:0]   ld_eff;
  logic [CHANNELS-1:0] ld_sync;
  logic               last_tick;
  logic               more_slots;

  // Slot table: not reset; only indices below SLOTS are ever written or played
  always_ff @(posedge hi_clk) begin
    if (i_cfg_we && (CNT_W'(i_cfg_addr) < CNT_W'(SLOTS)))
      tab[i_cfg_addr] <= {i_cfg_ch, i_cfg_hit_len, i_cfg_gnd_len,
                          i_cfg_pulse_count, i_cfg_hush_len, i_cfg_slot_len};
  end

  // Entry to load next: slot 0 from IDLE, otherwise the slot after the current one
  always_comb begin
    fs_edge     = i_frame_start & ~prev_fs;
    cnt_clamped = (i_slot_count > CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : i_slot_count;
    ld_idx      = (state == IDLE) ? 4'd0 : o_slot + 4'd1;
    ld          = tab[ld_idx];
    ld_eff      = (ld.slot_len < LEN_W'(2)) ? LEN_W'(2) : ld.slot_len;
    ld_sync     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ld.ch == 4'(i)) ld_sync[i] = 1'b1;
    end
    last_tick   = (cnt == eff_len - LEN_W'(1));
    more_slots  = (CNT_W'(o_slot) + CNT_W'(1)) < frame_cnt;
  end

  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      prev_fs       <= 1'b0;
      cnt           <= '0;
      eff_len       <= '0;
      frame_cnt     <= '0;
      o_sync        <= '0;
      o_hit_len     <= '0;
      o_gnd_len     <= '0;
      o_pulse_count <= '0;
      o_hush_len    <= '0;
      o_slot        <= '0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      prev_fs      <= i_frame_start;
      o_sync       <= '0;
      o_frame_done <= 1'b0;
      o_overrun    <= fs_edge && (state != IDLE);
      case (state)
        IDLE: begin
          if (fs_edge && i_enable && (cnt_clamped != '0)) begin
            o_sync        <= ld_sync;
            o_hit_len     <= ld.hit;
            o_gnd_len     <= ld.gnd;
            o_pulse_count <= ld.pcount;
            o_hush_len    <= ld.hush;
            eff_len       <= ld_eff;
            cnt           <= '0;
            o_slot        <= '0;
            o_busy        <= 1'b1;
            frame_cnt     <= cnt_clamped;
            state         <= SYNC;
          end
        end
        SYNC: begin
          cnt   <= cnt + LEN_W'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (!last_tick) begin
            cnt <= cnt + LEN_W'(1);
          end else if (!i_enable) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (more_slots) begin
            o_sync        <= ld_sync;
            o_hit_len     <= ld.hit;
            o_gnd_len     <= ld.gnd;
            o_pulse_count <= ld.pcount;
            o_hush_len    <= ld.hush;
            eff_len       <= ld_eff;
            cnt           <= '0;
            o_slot        <= o_slot + 4'd1;
            state         <= SYNC;
          end else begin
            o_frame_done <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Sequences up to `SLOTS` firing slots per frame across a bank of `pulse_channel` instances. Each slot drives one channel's sync edge and holds that channel's pulse parameters stable on a shared parameter bus for the whole slot. A frame-start strobe from the acquisition controller starts the frame. A host-side write port configures the slot table.

## Interface
- `CHANNELS`, default 4: number of driven pulse channels, 1..16.
- `SLOTS`, default 8: slot-table depth, 1..16.
- `rst_n` in 1: asynchronous, active-low reset.
- `hi_clk` in 1: 200 MHz clock, 5 ns tick.
- `i_enable` in 1: when high, frames are allowed to start.
- `i_frame_start` in 1: level input; a rising edge requests a frame.
- `i_slot_count` in 5: active slots per frame; values above `SLOTS` are clamped to `SLOTS`.
- `i_cfg_we` in 1: table write strobe, one entry per cycle.
- `i_cfg_addr` in 4: table slot index; writes with addr >= `SLOTS` are ignored.
- `i_cfg_ch` in 4: target channel for the slot.
- `i_cfg_hit_len` in 8, `i_cfg_gnd_len` in 8, `i_cfg_pulse_count` in 4, `i_cfg_hush_len` in 16: pulse parameters for the slot.
- `i_cfg_slot_len` in 16: slot duration in ticks.
- `o_sync` out `CHANNELS`: one-hot sync to the channels.
- `o_hit_len` out 8, `o_gnd_len` out 8, `o_pulse_count` out 4, `o_hush_len` out 16: shared parameter bus.
- `o_slot` out 4: index of the current slot.
- `o_busy` out 1: frame in progress.
- `o_frame_done` out 1: one-cycle pulse at normal frame completion.
- `o_overrun` out 1: one-cycle pulse when a frame-start edge is ignored.

## Operation
- Edge detect: `fs_edge = i_frame_start & ~prev_fs`, where `prev_fs` is registered every cycle.
- Slot table: `SLOTS` entries of {ch, hit, gnd, pcount, hush, slot_len}.
  - Written synchronously on `i_cfg_we`; writes are allowed at any time.
  - A slot's entry is sampled once, at slot load. Writes to the playing slot take effect at its next load.
- FSM states: IDLE, SYNC, WAIT, DONE.
- IDLE: on `fs_edge & i_enable & (clamped count != 0)`:
  - Load entry 0 into the output parameter registers.
  - Set `o_slot`=0 and `o_busy`=1, clear the slot counter, go to SYNC.
  - `fs_edge` with `i_enable`=0 or count=0 is ignored silently.
- SYNC (1 cycle): `o_sync[ch]`=1, all other bits 0.
  - If ch >= `CHANNELS`, all `o_sync` bits stay 0 (silent slot, still timed).
  - Go to WAIT.
- WAIT: the counter counts ticks from the SYNC cycle, so the SYNC cycle counts as tick 0.
  - Effective length = max(slot_len, 2).
  - At the last tick, if `i_enable`=0: abort to IDLE with `o_busy`=0 and no `o_frame_done`.
  - Else, if `o_slot`+1 < count: load the next entry, increment `o_slot`, go to SYNC.
  - Else: go to DONE.
- DONE (1 cycle): `o_frame_done`=1, then `o_busy`=0 and return to IDLE.
- Overrun: `fs_edge` in any state other than IDLE pulses `o_overrun` and is otherwise ignored.
- Parameter bus holds its last value in IDLE, so the final channel finishes its pulse and hush with stable inputs.
- `i_slot_count` is sampled at frame start and held for the whole frame.

## Timing
- Reset values:
  - All outputs are 0, FSM is IDLE, `prev_fs`=0.
  - Table contents are don't-care (not reset).
- Reset mid-frame clears everything immediately (asynchronous). No sync is issued after release until a new edge arrives.
- Start latency:
  - `i_frame_start` is sampled high at clock edge k, with `prev_fs`=0.
  - At edge k, the parameters load and the FSM enters SYNC.
  - `o_sync` is high for exactly the cycle after edge k.
  - Parameters are valid in that same cycle.
- Successive `o_sync` rising edges are exactly max(slot_len, 2) cycles apart.
- Frame length: the sum of the effective slot lengths, plus 1 DONE cycle.
- `o_frame_done` is asserted in the cycle after the last tick of the last slot.
- `o_busy` deasserts in the cycle after DONE.
- Simultaneous cfg write and load of the same slot: the load sees the old entry (read-before-write).

## Test plan
- Single-slot frame: slot0={ch2, hit 10, gnd 5, pc 3, hush 100, len 400}, count=1, edge.
  - `o_sync`=4'b0100 for 1 cycle, 1 cycle after the edge.
  - `o_frame_done` 400 cycles after the sync rise.
  - Bus holds 10/5/3/100 afterwards.
- Three slots, ch 0/1/3, lens 50/0/20.
  - Sync rises on successive channels at spacings 50, then 2.
  - `o_frame_done` 20 cycles after the third sync.
  - `o_slot` steps 0→1→2.
- Frame-start edge mid-frame: `o_overrun` pulses once, and frame timing is unchanged.
- Silent slot: slot ch=15 with `CHANNELS`=4 gives no `o_sync` bit and the full slot duration.
- `i_enable` dropped during slot 1 of 3 gives an abort at the end of slot 1, with no `o_frame_done` and `o_busy`=0.
- Async reset asserted during WAIT:
  - All outputs are 0 immediately.
  - After release, a new edge restarts the frame at slot 0.
